seq_gen: RTL and testbench

Serial bit-sequence generator. It is the transmit-side counterpart of the team's serial sequence detector (fsm). It loads a parallel pattern of programmable length and shifts it out MSB-first on a single-bit line, with a programmable repeat count and idle gap between repetitions. It sits upstream of the detector's x input and drives detector stimulus and bring-up traffic.

---
 rtl/seq_gen_if.sv | 29 ++
 rtl/seq_gen.sv | 113 +++++++++++
 tb/tb_seq_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_if.sv
// seq_gen_if: control, pattern and serial-output bundle between a stimulus source and seq_gen.
// The master drives requests and pattern data; the slave (seq_gen) drives the serial line and status.
interface seq_gen_if #(
    parameter int MAXLEN = 8,
    parameter int LENW   = 4,
    parameter int CNTW   = 4
);
    logic              start;
    logic              abort;
    logic [MAXLEN-1:0] pattern;
    logic [LENW-1:0]   len;
    logic [CNTW-1:0]   repeat_cnt;
    logic [CNTW-1:0]   gap;
    logic              x;
    logic              x_valid;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, pattern, len, repeat_cnt, gap,
        input  x, x_valid, busy, done, err
    );

    modport slave (
        input  start, abort, pattern, len, repeat_cnt, gap,
        output x, x_valid, busy, done, err
    );
endinterface

// File: rtl/seq_gen.sv
// seq_gen: serial MSB-first pattern generator with programmable repeat count and inter-repeat gap.
// Latency 1 cycle from accepted start to first bit; no backpressure, start is only sampled in IDLE.
module seq_gen #(
    parameter int MAXLEN = 8,
    parameter int LENW   = 4,
    parameter int CNTW   = 4
) (
    input  logic   clk,
    input  logic   rst,
    seq_gen_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [MAXLEN-1:0] pat_q,      pat_d;
    logic [LENW-1:0]   len_q,      len_d;
    logic [CNTW-1:0]   gap_q,      gap_d;
    logic [LENW-1:0]   bit_idx_q,  bit_idx_d;
    logic [CNTW-1:0]   rep_left_q, rep_left_d;
    logic [CNTW-1:0]   gap_ctr_q,  gap_ctr_d;
    logic              err_q,      err_d;
    logic [MAXLEN-1:0] pat_sh;
    logic              len_bad;

    assign len_bad = (bus.len == '0) || (bus.len > LENW'(MAXLEN));

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        gap_d      = gap_q;
        bit_idx_d  = bit_idx_q;
        rep_left_d = rep_left_q;
        gap_ctr_d  = gap_ctr_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        pat_d      = bus.pattern;
                        len_d      = bus.len;
                        gap_d      = bus.gap;
                        bit_idx_d  = bus.len - LENW'(1);
                        rep_left_d = bus.repeat_cnt;
                        state_d    = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (bit_idx_q != '0) begin
                    bit_idx_d = bit_idx_q - LENW'(1);
                end else if (rep_left_q == '0) begin
                    state_d = S_DONE;
                end else if (gap_q == '0) begin
                    // back-to-back repetition: reload without a bubble
                    bit_idx_d  = len_q - LENW'(1);
                    rep_left_d = rep_left_q - CNTW'(1);
                end else begin
                    gap_ctr_d  = gap_q - CNTW'(1);
                    rep_left_d = rep_left_q - CNTW'(1);
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_ctr_q == '0) begin
                    bit_idx_d = len_q - LENW'(1);
                    state_d   = S_SHIFT;
                end else begin
                    gap_ctr_d = gap_ctr_q - CNTW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            bit_idx_q  <= '0;
            rep_left_q <= '0;
            gap_ctr_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            bit_idx_q  <= bit_idx_d;
            rep_left_q <= rep_left_d;
            gap_ctr_q  <= gap_ctr_d;
            err_q      <= err_d;
        end
    end

    // Shift rather than index so the LENW-wide index never needs narrowing.
    assign pat_sh      = pat_q >> bit_idx_q;
    assign bus.x       = (state_q == S_SHIFT) & pat_sh[0];
    assign bus.x_valid = (state_q == S_SHIFT);
    assign bus.busy    = (state_q == S_SHIFT) || (state_q == S_GAP);
    assign bus.done    = (state_q == S_DONE);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: randomized and directed checks of seq_gen against a per-cycle output stream model.
// Observed vector per cycle is {x_valid, x, busy, done, err}.
module tb_seq_gen;
    localparam int MAXLEN = 8;
    localparam int LENW   = 4;
    localparam int CNTW   = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [4:0] exp_q[$];

    seq_gen_if #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) bus ();

    seq_gen #(.MAXLEN(MAXLEN), .LENW(LENW), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] obs();
        return {bus.x_valid, bus.x, bus.busy, bus.done, bus.err};
    endfunction

    // Expected stream: every bit of every repetition, gap idles between repetitions,
    // one done cycle, then one idle cycle.
    task automatic build_model(input logic [7:0] pat, input int len, input int rep, input int gap);
        exp_q.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int b = len - 1; b >= 0; b--) exp_q.push_back({1'b1, pat[b], 1'b1, 1'b0, 1'b0});
            if (r != rep) for (int g = 0; g < gap; g++) exp_q.push_back(5'b00100);
        end
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00000);
    endtask

    task automatic launch(input logic [7:0] pat, input int len, input int rep, input int gap);
        @(negedge clk);
        bus.pattern    = pat;
        bus.len        = LENW'(len);
        bus.repeat_cnt = CNTW'(rep);
        bus.gap        = CNTW'(gap);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        // Scramble inputs after acceptance; the DUT must use its latched copies.
        bus.pattern    = 8'($urandom);
        bus.len        = LENW'($urandom);
        bus.repeat_cnt = CNTW'($urandom);
        bus.gap        = CNTW'($urandom);
    endtask

    task automatic run_tx(input string name, input logic [7:0] pat, input int len,
                          input int rep, input int gap);
        logic [4:0] o;
        build_model(pat, len, rep, gap);
        launch(pat, len, rep, gap);
        for (int i = 0; i < exp_q.size(); i++) begin
            o = obs();
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL %s cycle %0d: got %b want %b (x_valid,x,busy,done,err)", name, i, o, exp_q[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [4:0] o;
        rst = 1'b0;
        bus.start = 1'b1; bus.abort = 1'b0; bus.pattern = 8'hFF;
        bus.len = 4'd4; bus.repeat_cnt = '0; bus.gap = '0;
        repeat (2) @(negedge clk);
        o = obs();
        tests++;
        if (o !== 5'b00000) begin
            fails++;
            $display("FAIL reset_state: got %b want 00000", o);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        o = obs();
        tests++;
        if (o !== 5'b00000) begin
            fails++;
            $display("FAIL reset_release_idle: got %b want 00000", o);
        end
    endtask

    task automatic test_basic();
        run_tx("basic_len4", 8'b0000_1011, 4, 0, 0);
    endtask

    task automatic test_gap();
        run_tx("gap1_rep2", 8'b0000_0101, 3, 2, 1);
    endtask

    task automatic test_err();
        int bad_lens[3] = '{0, 9, 15};
        logic [4:0] o;
        foreach (bad_lens[k]) begin
            @(negedge clk);
            bus.pattern = 8'($urandom);
            bus.len     = LENW'(bad_lens[k]);
            bus.start   = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            o = obs();
            tests++;
            if (o !== 5'b00001) begin
                fails++;
                $display("FAIL err_pulse len=%0d: got %b want 00001", bad_lens[k], o);
            end
            @(negedge clk);
            o = obs();
            tests++;
            if (o !== 5'b00000) begin
                fails++;
                $display("FAIL err_clears len=%0d: got %b want 00000", bad_lens[k], o);
            end
        end
    endtask

    task automatic test_abort();
        logic [4:0] o;
        logic [7:0] pat;
        int gap, abort_idx;
        pat = 8'($urandom);
        gap = int'($urandom_range(0, 2));
        // Fifth bit of the second repetition.
        abort_idx = 8 + gap + 4;
        build_model(pat, 8, 3, gap);
        launch(pat, 8, 3, gap);
        for (int i = 0; i <= abort_idx; i++) begin
            o = obs();
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL abort_stream cycle %0d: got %b want %b", i, o, exp_q[i]);
            end
            bus.start = (i == 3);
            bus.abort = (i == abort_idx);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            o = obs();
            tests++;
            if (o !== 5'b00000) begin
                fails++;
                $display("FAIL abort_idle +%0d: got %b want 00000", k, o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] o;
        logic [7:0] pat;
        pat = 8'b0011_0110;
        build_model(pat, 6, 1, 2);
        launch(pat, 6, 1, 2);
        for (int i = 0; i < 3; i++) begin
            o = obs();
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL pre_reset cycle %0d: got %b want %b", i, o, exp_q[i]);
            end
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1 o = obs();
        tests++;
        if (o !== 5'b00000) begin
            fails++;
            $display("FAIL async_reset_mid_shift: got %b want 00000", o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_tx("after_reset", 8'($urandom), int'($urandom_range(2, 8)), 0, 0);
    endtask

    task automatic test_len1();
        run_tx("len1_rep15", 8'b1010_0101, 1, 15, 0);
    endtask

    task automatic test_back_to_back();
        run_tx("max_rep_gap", 8'($urandom), 8, 15, 15);
        for (int n = 0; n < 10; n++) begin
            run_tx("random", 8'($urandom), int'($urandom_range(1, 8)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pattern = '0;
        bus.len = '0;
        bus.repeat_cnt = '0;
        bus.gap = '0;
        test_reset();
        test_basic();
        test_gap();
        test_err();
        test_abort();
        test_async_reset();
        test_len1();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
